complex_demul: RTL and testbench

- Inverse 45-degree rotator: recovers (a, b) from a rotated pair re = (a-b)*0.7071, im = (a+b)*0.7071.
  - a_out = (re+im)*0.7071
  - b_out = (im-re)*0.7071
- Sits on the return path after the forward 45-degree rotator, e.g. in the inverse-butterfly stage of the FFT datapath.
- Uses a single shared constant multiplier, time-multiplexed by an FSM.
- Valid/ready handshakes on both sides.

---
 rtl/complex_demul.sv | 109 ++++++++++
 tb/tb_complex_demul.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/complex_demul.sv
// Inverse 45-degree rotator for the FFT return path.
// One constant multiplier is shared between the a and b results.
module complex_demul #(
  parameter int N = 4,
  parameter int K = 23170
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(2**N)-1:0]   real_ip,
  input  logic [(2**N)-1:0]   image_ip,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [(2**N)-1:0]   a_op,
  output logic [(2**N)-1:0]   b_op,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int W = 2**N;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL_A = 2'd1;
  localparam logic [1:0] MUL_B = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [W:0] KC = (W+1)'(K);

  localparam logic signed [2*W+1:0] MAXV =
    {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] MINV =
    {{(W+3){1'b1}}, {(W-1){1'b0}}};

  logic [1:0]             state;
  logic signed [W:0]      s_a;
  logic signed [W:0]      s_b;
  logic signed [W:0]      mop;
  logic signed [2*W+1:0]  prod;
  logic signed [2*W+1:0]  shf;
  logic [W-1:0]           satv;
  logic                   take;
  logic                   give;
  logic signed [W:0]      sum_ab;
  logic signed [W:0]      dif_ab;

  assign in_ready  = !rst &&
    ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign give      = out_valid && out_ready;

  // one extra bit keeps the pre-add/subtract exact
  assign sum_ab = $signed({real_ip[W-1], real_ip})
                + $signed({image_ip[W-1], image_ip});
  assign dif_ab = $signed({image_ip[W-1], image_ip})
                - $signed({real_ip[W-1], real_ip});

  assign mop  = (state == MUL_B) ? s_b : s_a;
  assign prod = mop * KC;
  assign shf  = prod >>> (W-1);

  always_comb begin
    satv = shf[W-1:0];
    if (shf > MAXV)
      satv = {1'b0, {(W-1){1'b1}}};
    else if (shf < MINV)
      satv = {1'b1, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_a   <= '0;
      s_b   <= '0;
      a_op  <= '0;
      b_op  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            s_a   <= sum_ab;
            s_b   <= dif_ab;
            state <= MUL_A;
          end
        end
        MUL_A: begin
          a_op  <= satv;
          state <= MUL_B;
        end
        MUL_B: begin
          b_op  <= satv;
          state <= DONE;
        end
        DONE: begin
          if (give) begin
            if (take) begin
              s_a   <= sum_ab;
              s_b   <= dif_ab;
              state <= MUL_A;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_demul.sv
// Directed bench for complex_demul.
// Expected values are hand-computed from the rotation formulas.
module tb_complex_demul;

  logic        clk;
  logic        rst;
  logic [15:0] real_ip;
  logic [15:0] image_ip;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_op;
  logic [15:0] b_op;
  logic        out_valid;
  logic        out_ready;

  int total;
  int bad;

  complex_demul dut (
    .clk       (clk),
    .rst       (rst),
    .real_ip   (real_ip),
    .image_ip  (image_ip),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_op      (a_op),
    .b_op      (b_op),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] r,
                      input logic [15:0] i);
    int n;
    real_ip  = r;
    image_ip = i;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_wait", 32'(n < 20), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic getres(input string tag,
                        input logic [15:0] ea,
                        input logic [15:0] eb);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(n < 20), 32'd1);
    chk({tag, "_a"}, 32'(a_op), 32'(ea));
    chk({tag, "_b"}, 32'(b_op), 32'(eb));
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [15:0] ha;
    logic [15:0] hb;
    logic        seen;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    real_ip   = '0;
    image_ip  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_a", 32'(a_op), 32'd0);
    chk("rst_b", 32'(b_op), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd0);
    #12;
    rst = 1'b0;
    step();
    chk("rel_ir", 32'(in_ready), 32'd1);

    send(16'h4000, 16'h4000);
    chk("lat_ov0", 32'(out_valid), 32'd0);
    getres("nom", 16'h5A82, 16'h0000);

    send(16'd5656, 16'd8485);
    getres("trip", 16'd9998, 16'd2000);

    send(16'h0000, 16'hFFFF);
    getres("floor", 16'hFFFF, 16'hFFFF);

    send(16'h8000, 16'h8000);
    getres("satn", 16'h8000, 16'h0000);

    send(16'h7FFF, 16'h7FFF);
    getres("satp", 16'h7FFF, 16'h0000);

    // idle keeps last result
    step();
    chk("idle_a", 32'(a_op), 32'h7FFF);
    chk("idle_ov", 32'(out_valid), 32'd0);

    // backpressure with a pair waiting
    out_ready = 1'b0;
    send(16'd5656, 16'd8485);
    while (!out_valid) step();
    ha = a_op;
    hb = b_op;
    real_ip  = 16'h4000;
    image_ip = 16'h4000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_ir", 32'(in_ready), 32'd0);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_a", 32'(a_op), 32'(ha));
      chk("bp_b", 32'(b_op), 32'(hb));
    end
    chk("bp_hold_a", 32'(a_op), 32'd9998);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ir", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_next_ov", 32'(out_valid), 32'd0);
    getres("bp_next", 16'h5A82, 16'h0000);

    // async reset between edges clears outputs at once
    send(16'd5656, 16'd8485);
    while (!out_valid) step();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_a", 32'(a_op), 32'd0);
    chk("arst_b", 32'(b_op), 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("arst_ir", 32'(in_ready), 32'd1);

    // reset while in MUL_A drops the pair
    send(16'h4000, 16'h4000);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_ov", 32'(out_valid), 32'd0);
    chk("mid_a", 32'(a_op), 32'd0);
    step();
    #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_lost", 32'(seen), 32'd0);
    send(16'd5656, 16'd8485);
    getres("mid_new", 16'd9998, 16'd2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
